// File: rtl/pll_chain_sequencer_pkg.sv
// pll_chain_sequencer_pkg: state encoding and counter sizing shared by the PLL chain sequencer
package pll_chain_sequencer_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    function automatic int cnt_width(input int hold, input int timeout);
        return $clog2(hold > timeout ? hold : timeout) + 1;
    endfunction
endpackage

// File: rtl/pll_chain_sequencer_lock_sync.sv
// lock_sync: parameterized-width 2-flop synchronizer with synchronous clear
module lock_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_chain_sequencer.sv
// pll_chain_sequencer: releases chained PLL resets stage by stage, retries on timeout, re-sequences on lock loss.
// Define PLL_SEQ_LOCK_DEBOUNCE_EN to require LOCK_STABLE_CYCLES consecutive lock cycles before advancing.
module pll_chain_sequencer
    import pll_chain_sequencer_pkg::*;
#(
    parameter int PLL_NUM            = 3,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int LOCK_TIMEOUT       = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int LOCK_STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               START,
    input  logic [PLL_NUM-1:0] LOCKED_IN,
    output logic [PLL_NUM-1:0] PLL_RST,
    output logic               ALL_LOCKED,
    output logic               BUSY,
    output logic               FAIL,
    output logic [3:0]         FAIL_STAGE,
    output logic [3:0]         RETRY_CNT
);
    localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT);

    if (PLL_NUM < 1 || PLL_NUM > 16 || RST_HOLD_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_params
        $error("pll_chain_sequencer: parameter out of range");
    end

    state_t             state, state_n;
    logic [3:0]         stage, stage_n, retry, retry_n, low_idx;
    logic [CW-1:0]      cnt, cnt_n;
    logic [PLL_NUM-1:0] lk, sel, prst_n;
    logic               fail_n, go_hold, any_low, lk_cur, lk_ok;

    lock_sync #(.W(PLL_NUM)) u_sync (.clk(clk), .rst(RST), .d(LOCKED_IN), .q(lk));

    assign sel    = PLL_NUM'(1) << stage;
    assign lk_cur = |(lk & sel);

    always_comb begin
        any_low = 1'b0;
        low_idx = '0;
        for (int i = PLL_NUM - 1; i >= 0; i--)
            if (!lk[i]) begin
                any_low = 1'b1;
                low_idx = 4'(i);
            end
    end

`ifdef PLL_SEQ_LOCK_DEBOUNCE_EN
    localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
    logic [SW-1:0] stab;
    always_ff @(posedge clk) begin
        if (RST || state != WAIT || !lk_cur) stab <= '0;
        else if (!(&stab)) stab <= stab + 1'b1;
    end
    assign lk_ok = lk_cur && (int'(stab) >= LOCK_STABLE_CYCLES - 1);
`else
    assign lk_ok = lk_cur;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= IDLE;
            stage   <= '0;
            retry   <= '0;
            cnt     <= '0;
            FAIL    <= 1'b0;
            PLL_RST <= '1;
        end else begin
            state   <= state_n;
            stage   <= stage_n;
            retry   <= retry_n;
            cnt     <= cnt_n;
            FAIL    <= fail_n;
            PLL_RST <= prst_n;
        end
    end

    // Every HOLD entry re-asserts the entered stage and everything downstream of it.
    always_comb begin
        state_n = state;
        stage_n = stage;
        retry_n = retry;
        fail_n  = FAIL;
        prst_n  = PLL_RST;
        go_hold = 1'b0;
        cnt_n   = (&cnt) ? cnt : cnt + 1'b1;
        if ((state == HOLD || state == WAIT) && any_low && low_idx < stage) begin
            go_hold = 1'b1;
            stage_n = low_idx;
            retry_n = '0;
        end else begin
            case (state)
                IDLE, ERROR: if (START) begin
                    go_hold = 1'b1;
                    stage_n = '0;
                    retry_n = '0;
                end
                HOLD: if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                    prst_n  = PLL_RST & ~sel;
                end
                WAIT: if (lk_ok) begin
                    if (stage == 4'(PLL_NUM - 1)) state_n = DONE;
                    else begin
                        go_hold = 1'b1;
                        stage_n = stage + 1'b1;
                        retry_n = '0;
                    end
                end else if (cnt_n == CW'(LOCK_TIMEOUT)) begin
                    if (retry < 4'(MAX_RETRIES)) begin
                        go_hold = 1'b1;
                        retry_n = retry + 1'b1;
                    end else begin
                        state_n = ERROR;
                        fail_n  = 1'b1;
                        prst_n  = '1;
                    end
                end
                DONE: if (any_low) begin
                    go_hold = 1'b1;
                    stage_n = low_idx;
                    retry_n = '0;
                end
                default: begin
                    state_n = IDLE;
                    prst_n  = '1;
                end
            endcase
        end
        if (go_hold) begin
            state_n = HOLD;
            cnt_n   = '0;
            prst_n  = {PLL_NUM{1'b1}} << stage_n;
        end
    end

    always_comb begin
        ALL_LOCKED = state == DONE;
        BUSY       = state == HOLD || state == WAIT;
        FAIL_STAGE = stage;
        RETRY_CNT  = retry;
    end
endmodule

// File: tb/tb_pll_chain_sequencer.sv
// tb_pll_chain_sequencer: directed and randomized checks against an event-time reference model.
module tb_pll_chain_sequencer;
    localparam int N  = 3;
    localparam int H  = 8;
    localparam int T  = 64;
    localparam int MR = 2;
    localparam int LD = 20;
    localparam int M_IDLE = 0, M_HOLD = 1, M_WAIT = 2, M_DONE = 3, M_ERR = 4;

    logic         clk = 1'b0;
    logic         RST, START;
    logic [N-1:0] LOCKED_IN, PLL_RST;
    logic         ALL_LOCKED, BUSY, FAIL;
    logic [3:0]   FAIL_STAGE, RETRY_CNT;

    always #5 clk = ~clk;

    pll_chain_sequencer #(
        .PLL_NUM(N), .RST_HOLD_CYCLES(H), .LOCK_TIMEOUT(T), .MAX_RETRIES(MR), .LOCK_STABLE_CYCLES(16)
    ) dut (
        .clk(clk), .RST(RST), .START(START), .LOCKED_IN(LOCKED_IN), .PLL_RST(PLL_RST),
        .ALL_LOCKED(ALL_LOCKED), .BUSY(BUSY), .FAIL(FAIL), .FAIL_STAGE(FAIL_STAGE), .RETRY_CNT(RETRY_CNT)
    );

    int checks = 0, errors = 0;
    bit mon = 0;
    logic [N-1:0] broken = '0, drop = '0;
    int lcnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases are timed by absolute edge numbers, lock seen two edges late.
    int m_state = M_IDLE, m_stage = 0, m_retry = 0, edge_no = 0, ph = 0;
    logic m_fail = 1'b0;
    logic [N-1:0] m_prst = '1, q1 = '0, q2 = '0;

    task automatic enter_hold(input int k);
        m_state = M_HOLD;
        m_stage = k;
        ph = edge_no;
        for (int j = k; j < N; j++) m_prst[j] = 1'b1;
    endtask

    always @(posedge clk) begin
        logic [N-1:0] lk;
        int fz;
        lk = q2;
        q2 = q1;
        q1 = LOCKED_IN;
        edge_no++;
        fz = N;
        for (int j = N - 1; j >= 0; j--) if (!lk[j]) fz = j;
        if (RST) begin
            q1 = '0; q2 = '0;
            m_state = M_IDLE; m_stage = 0; m_retry = 0; m_fail = 1'b0; m_prst = '1;
        end else if ((m_state == M_HOLD || m_state == M_WAIT) && fz < m_stage) begin
            enter_hold(fz);
            m_retry = 0;
        end else if ((m_state == M_IDLE || m_state == M_ERR) && START) begin
            enter_hold(0);
            m_retry = 0;
        end else if (m_state == M_HOLD && edge_no - ph == H) begin
            m_state = M_WAIT;
            m_prst[m_stage] = 1'b0;
            ph = edge_no;
        end else if (m_state == M_WAIT && lk[m_stage]) begin
            if (m_stage == N - 1) m_state = M_DONE;
            else begin
                enter_hold(m_stage + 1);
                m_retry = 0;
            end
        end else if (m_state == M_WAIT && edge_no - ph == T) begin
            if (m_retry < MR) begin
                enter_hold(m_stage);
                m_retry++;
            end else begin
                m_state = M_ERR;
                m_fail = 1'b1;
                m_prst = '1;
            end
        end else if (m_state == M_DONE && fz < N) begin
            enter_hold(fz);
            m_retry = 0;
        end
    end

    // One cycle: compare at the falling edge, then update the PLL lock stubs.
    task automatic cyc();
        @(negedge clk);
        if (mon) begin
            check("pll_rst", 32'(PLL_RST), 32'(m_prst));
            check("all_locked", 32'(ALL_LOCKED), 32'(m_state == M_DONE));
            check("busy", 32'(BUSY), 32'(m_state == M_HOLD || m_state == M_WAIT));
            check("fail", 32'(FAIL), 32'(m_fail));
            check("fail_stage", 32'(FAIL_STAGE), 32'(m_stage));
            check("retry_cnt", 32'(RETRY_CNT), 32'(m_retry));
        end
        for (int i = 0; i < N; i++) begin
            if (PLL_RST[i] !== 1'b0) lcnt[i] = 0;
            else if (lcnt[i] < LD) lcnt[i]++;
            LOCKED_IN[i] = PLL_RST[i] === 1'b0 && lcnt[i] >= LD && !broken[i] && !drop[i];
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        cyc();
        START = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        int r;
        RST = 1'b1; START = 1'b0; LOCKED_IN = '0;
        for (int i = 0; i < N; i++) lcnt[i] = 0;
        cyc();
        mon = 1;
        cyc();
        RST = 1'b0;
        check("rst_pll_rst", 32'(PLL_RST), 32'h7);
        check("rst_all_locked", 32'(ALL_LOCKED), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_fail", 32'(FAIL), 32'h0);

        pulse_start();
        for (int k = 0; k < 200 && ALL_LOCKED !== 1'b1; k++) cyc();
        check("nominal_all_locked", 32'(ALL_LOCKED), 32'h1);
        check("nominal_busy", 32'(BUSY), 32'h0);
        check("nominal_pll_rst", 32'(PLL_RST), 32'h0);

        drop[1] = 1'b1;
        for (int k = 0; k < 10 && ALL_LOCKED === 1'b1; k++) cyc();
        check("loss_all_locked", 32'(ALL_LOCKED), 32'h0);
        check("loss_pll_rst", 32'(PLL_RST), 32'h6);
        drop = '0;
        for (int k = 0; k < 200 && ALL_LOCKED !== 1'b1; k++) cyc();
        check("relock_all_locked", 32'(ALL_LOCKED), 32'h1);

        broken[1] = 1'b1;
        do_reset();
        pulse_start();
        for (int k = 0; k < 700 && FAIL !== 1'b1; k++) cyc();
        check("timeout_fail", 32'(FAIL), 32'h1);
        check("timeout_fail_stage", 32'(FAIL_STAGE), 32'h1);
        check("timeout_pll_rst", 32'(PLL_RST), 32'h7);
        check("timeout_retry_cnt", 32'(RETRY_CNT), 32'h2);
        check("timeout_busy", 32'(BUSY), 32'h0);
        broken = '0;
        pulse_start();
        for (int k = 0; k < 200 && ALL_LOCKED !== 1'b1; k++) cyc();
        check("restart_all_locked", 32'(ALL_LOCKED), 32'h1);
        check("restart_fail_sticky", 32'(FAIL), 32'h1);

        do_reset();
        pulse_start();
        for (int k = 0; k < 200 && !(PLL_RST === 3'b000 && BUSY === 1'b1); k++) cyc();
        check("wait2_pll_rst", 32'(PLL_RST), 32'h0);
        check("wait2_stage", 32'(FAIL_STAGE), 32'h2);
        repeat (5) cyc();
        do_reset();
        check("midrst_pll_rst", 32'(PLL_RST), 32'h7);
        check("midrst_retry_cnt", 32'(RETRY_CNT), 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        check("midrst_fail", 32'(FAIL), 32'h0);

        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 999);
            START = r < 20;
            RST = r >= 20 && r < 23;
            if (r >= 30 && r < 40) broken = broken ^ (N'(1) << $urandom_range(0, N - 1));
            if (r >= 40 && r < 55) drop = N'($urandom_range(0, (1 << N) - 1));
            if (r >= 55 && r < 120) drop = '0;
            cyc();
        end
        START = 1'b0;
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
